// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce: two-flop synchroniser, per-key bounce filter, press/release
// pulses and key-code encoder. Optional KEY_REPEAT_EN adds hold auto-repeat.
// Revision: 1.0
// ============================================================================
module key_debounce #(
   parameter int NKEYS            = 5,
   parameter int DEBOUNCE_CYC     = 500000,
   parameter int REPEAT_DELAY_CYC = 25000000,
   parameter int REPEAT_RATE_CYC  = 5000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NKEYS-1:0] key_raw_n,
   output logic [NKEYS-1:0] key_db_n,
   output logic [NKEYS-1:0] press_p,
   output logic [NKEYS-1:0] release_p,
   output logic             key_valid,
   output logic [2:0]       key_code
);

   localparam int CW = $clog2(DEBOUNCE_CYC);

   if (NKEYS < 1 || NKEYS > 8) begin : g_bad_nkeys
      $error("key_debounce: NKEYS must be 1..8");
   end
   if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
      $error("key_debounce: DEBOUNCE_CYC must be at least 2");
   end
   if (REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_repeat
      $error("key_debounce: repeat intervals must be at least 1");
   end

   logic [NKEYS-1:0] sync1_q, sync2_q;
   logic [NKEYS-1:0] db_q, db_d;
   logic [NKEYS-1:0] press_q, press_d;
   logic [NKEYS-1:0] rel_q, rel_d;
   logic [CW-1:0]    cnt_q [NKEYS];
   logic [CW-1:0]    cnt_d [NKEYS];
   logic             valid_q, valid_d;
   logic [2:0]       code_q, code_d;
   logic [NKEYS-1:0] w_press_edge;

   // Any agreeing sample clears the run, so only an unbroken disagreement flips the level.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < NKEYS; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
               db_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign w_press_edge = db_q & ~db_d;
   assign rel_d        = ~db_q & db_d;

`ifdef KEY_REPEAT_EN
   localparam int TMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   logic [TW-1:0]    tmr_q [NKEYS];
   logic [TW-1:0]    tmr_d [NKEYS];
   logic [NKEYS-1:0] rep_q, rep_d;

   // rep_q marks that the first delay has expired and the shorter rate now applies.
   always_comb begin
      press_d = w_press_edge;
      rep_d   = rep_q;
      for (int i = 0; i < NKEYS; i++) begin
         tmr_d[i] = tmr_q[i];
         if (db_d[i] || db_q[i]) begin
            tmr_d[i] = '0;
            rep_d[i] = 1'b0;
         end else begin
            tmr_d[i] = tmr_q[i] + TW'(1);
            if ((!rep_q[i] && tmr_d[i] == TW'(REPEAT_DELAY_CYC)) ||
                ( rep_q[i] && tmr_d[i] == TW'(REPEAT_RATE_CYC))) begin
               press_d[i] = 1'b1;
               tmr_d[i]   = '0;
               rep_d[i]   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
         for (int i = 0; i < NKEYS; i++) tmr_q[i] <= '0;
      end else begin
         rep_q <= rep_d;
         for (int i = 0; i < NKEYS; i++) tmr_q[i] <= tmr_d[i];
      end
   end
`else
   assign press_d = w_press_edge;
`endif

   always_comb begin
      valid_d = ~&db_q;
      code_d  = 3'd0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (!db_q[i]) code_d = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         db_q    <= '1;
         press_q <= '0;
         rel_q   <= '0;
         valid_q <= 1'b0;
         code_q  <= 3'd0;
         for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= key_raw_n;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         valid_q <= valid_d;
         code_q  <= code_d;
         for (int i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign key_db_n  = db_q;
   assign press_p   = press_q;
   assign release_p = rel_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;

endmodule
`default_nettype wire

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input conditioning stage for the board's active-low pushbuttons.
- Sits directly upstream of the seven-segment key decoder.
- Synchronises each raw key, filters contact bounce, and presents clean active-low levels that drop straight into the decoder's key inputs.
- Also provides one-cycle press/release pulses and a priority-encoded key code for sequential consumers.

Parameters:
- NKEYS, 5, number of key inputs (1..8).
- DEBOUNCE_CYC, 500000, consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- REPEAT_DELAY_CYC, 25000000, hold time before the first auto-repeat pulse (used only with KEY_REPEAT_EN).
- REPEAT_RATE_CYC, 5000000, interval between subsequent auto-repeat pulses (used only with KEY_REPEAT_EN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_raw_n  input  NKEYS  raw pushbuttons, active-low, asynchronous to clk.
- key_db_n  output  NKEYS  debounced levels, active-low; bit i = key i.
- press_p  output  NKEYS  one-cycle pulse per accepted press, plus auto-repeat pulses when enabled.
- release_p  output  NKEYS  one-cycle pulse per accepted release.
- key_valid  output  1  high while any debounced key is pressed.
- key_code  output  3  index of the lowest-numbered pressed key; 0 when key_valid=0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Asserting rst_n=0 immediately forces:
  - key_db_n = all 1s, press_p = 0, release_p = 0, key_valid = 0, key_code = 0.
  - Synchroniser flops = 1; counters = 0.
- Synchroniser: two flops per key; no logic between them. The second-stage value is s[i].
- Per-key filter: counter cnt[i], width $clog2(DEBOUNCE_CYC).
  - If s[i] == key_db_n[i]: cnt[i] <= 0.
  - If s[i] != key_db_n[i] and cnt[i] < DEBOUNCE_CYC-1: cnt[i] increments.
  - If s[i] != key_db_n[i] and cnt[i] == DEBOUNCE_CYC-1: key_db_n[i] <= s[i] and cnt[i] <= 0.
  - A single agreeing sample restarts the count, so a glitch shorter than DEBOUNCE_CYC cycles never propagates.
- Latency: a clean edge on key_raw_n[i] appears on key_db_n[i] exactly 2+DEBOUNCE_CYC rising edges later.
- Pulses: registered on the same edge that key_db_n[i] changes.
  - 1→0 asserts press_p[i] for exactly one cycle.
  - 0→1 asserts release_p[i] for exactly one cycle.
- Keys are fully independent. Simultaneous transitions on several keys produce simultaneous pulses on each.
- key_valid and key_code are registered from the current key_db_n (one cycle after key_db_n). Lowest index wins, matching the decoder's key1-first priority.
- Reset mid-filter: the count is discarded. After release of rst_n, the key must again be stable for the full window from the all-released state. No press pulse is generated at reset release when keys are already high.
- A key held low through reset release is accepted as a press after 2+DEBOUNCE_CYC cycles, with a press_p pulse.

Optional Feature:
- KEY_REPEAT_EN defined: each key gets a hold timer.
  - The timer starts at 0 on the press_p edge and counts while key_db_n[i]=0.
  - When it reaches REPEAT_DELAY_CYC, press_p[i] pulses and the timer reloads to count REPEAT_RATE_CYC.
  - press_p[i] pulses again on every REPEAT_RATE_CYC expiry.
  - Release clears the timer in the same cycle as release_p.
  - release_p is unaffected.
- Not defined: no repeat timers are synthesised. REPEAT_* parameters are ignored, and press_p pulses only on the debounced 1→0 edge.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3):
- Reset with rst_n=0 asserted mid-cycle → all outputs at reset values immediately; key_db_n=5'b11111.
- key_raw_n[0] clean 1→0 at edge 0, held → key_db_n[0]=0 and press_p[0]=1 at edge 6 only; key_valid=1 and key_code=0 at edge 7.
- key_raw_n[2] bounces 0 for 3 cycles, 1 for 1 cycle, repeatedly → key_db_n[2] stays 1, press_p=0 throughout.
- Keys 1 and 3 released together after being held → release_p=5'b01010 for one cycle; key_code goes 1→0 with key_valid=0.
- rst_n pulsed low at cnt=2 during a press → no press_p. Key held afterwards → press_p 6 cycles after rst_n rises.
- KEY_REPEAT_EN defined, key 4 held 30 cycles past acceptance → press_p[4] at hold offsets 0, 10, 13, 16, 19, 22, 25, 28. Without the macro → only offset 0.
